// File: rtl/image_pkg.sv
// Shared image-pipeline types, width helpers and window indexing used by
// sliding_window and window_convolution.
package image_pkg;

  localparam int DEFAULT_ITEM_BITS   = 8;
  localparam int DEFAULT_KERNEL_SIZE = 3;
  localparam int DEFAULT_COEFF_BITS  = 8;
  localparam int DEFAULT_SHIFT       = 4;
  localparam int TAG_BITS            = 16;

  typedef logic        [DEFAULT_ITEM_BITS-1:0]  ItemType;
  typedef logic signed [DEFAULT_COEFF_BITS-1:0] CoeffType;
  typedef logic        [TAG_BITS-1:0]           TagType;

  // Unsigned pixel gains a zero sign bit before the signed multiply.
  function automatic int product_bits(int item_bits, int coeff_bits);
    return item_bits + 1 + coeff_bits;
  endfunction

  function automatic int sum_bits(int item_bits, int coeff_bits, int kernel_size);
    return product_bits(item_bits, coeff_bits) + $clog2(kernel_size * kernel_size);
  endfunction

  localparam int PRODUCT_BITS = product_bits(DEFAULT_ITEM_BITS, DEFAULT_COEFF_BITS);
  localparam int SUM_BITS     = sum_bits(DEFAULT_ITEM_BITS, DEFAULT_COEFF_BITS, DEFAULT_KERNEL_SIZE);

  // Element [row][column] of a flattened window; row 0 is the top row.
  function automatic int window_index(int row, int column, int kernel_size);
    return row * kernel_size + column;
  endfunction

endpackage

// File: rtl/internal_axi4_stream_if.sv
// Valid/ready stream with row/column tags travelling alongside the data.
interface internal_axi4_stream_if
  import image_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_ITEM_BITS
) ();

  logic                 valid;
  logic                 ready;
  logic [DATA_BITS-1:0] data;
  TagType               row;
  TagType               column;

  modport master (output valid, data, row, column, input ready);
  modport slave  (input valid, data, row, column, output ready);

endinterface

// File: rtl/window_convolution_signed_adder_tree.sv
// Combinational balanced reduction of N signed operands; output is wide
// enough that the sum can never overflow.
module signed_adder_tree #(
  parameter int N       = 9,
  parameter int IN_BITS = 17
) (
  input  logic        [N*IN_BITS-1:0]            operands,
  output logic signed [IN_BITS+$clog2(N)-1:0]    sum
);

  localparam int OUT_BITS = IN_BITS + $clog2(N);
  localparam int LEVELS   = $clog2(N);
  localparam int LEAVES   = 1 << LEVELS;

  // Level 0 holds the sign-extended operands padded with zeros up to a power
  // of two; every further level halves the node count.
  for (genvar lvl = 0; lvl <= LEVELS; lvl++) begin : g_level
    localparam int WIDTH = LEAVES >> lvl;
    logic signed [OUT_BITS-1:0] partial [WIDTH];

    if (lvl == 0) begin : g_leaves
      for (genvar leaf = 0; leaf < WIDTH; leaf++) begin : g_leaf
        if (leaf < N) begin : g_operand
          assign partial[leaf] = OUT_BITS'($signed(operands[leaf*IN_BITS +: IN_BITS]));
        end else begin : g_pad
          assign partial[leaf] = '0;
        end
      end
    end else begin : g_sums
      for (genvar node = 0; node < WIDTH; node++) begin : g_node
        assign partial[node] = g_level[lvl-1].partial[2*node] + g_level[lvl-1].partial[2*node+1];
      end
    end
  end

  assign sum = g_level[LEVELS].partial[0];

endmodule

// File: rtl/window_convolution.sv
// Three-stage convolution of a KxK window with a loadable signed kernel:
// products, adder-tree sum, then round/shift/saturate to one pixel.
module window_convolution
  import image_pkg::*;
#(
  parameter int ITEM_BITS   = DEFAULT_ITEM_BITS,
  parameter int KERNEL_SIZE = DEFAULT_KERNEL_SIZE,
  parameter int COEFF_BITS  = DEFAULT_COEFF_BITS,
  parameter int SHIFT       = DEFAULT_SHIFT
) (
  input  logic                                         clock_i,
  input  logic                                         reset_ni,
  internal_axi4_stream_if.slave                        window_slave_port,
  internal_axi4_stream_if.master                       pixel_master_port,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*COEFF_BITS-1:0] kernel_i,
  input  logic                                         kernel_load_i
);

  localparam int WINDOW_ITEMS = KERNEL_SIZE * KERNEL_SIZE;
  localparam int KERNEL_BITS  = WINDOW_ITEMS * COEFF_BITS;
  localparam int PROD_BITS    = product_bits(ITEM_BITS, COEFF_BITS);
  localparam int ACC_BITS     = sum_bits(ITEM_BITS, COEFF_BITS, KERNEL_SIZE);
  localparam int CENTER       = (KERNEL_SIZE - 1) / 2;

  function automatic logic [KERNEL_BITS-1:0] identity_kernel();
    logic [KERNEL_BITS-1:0] coeffs;
    coeffs = '0;
    coeffs[window_index(CENTER, CENTER, KERNEL_SIZE)*COEFF_BITS +: COEFF_BITS] = COEFF_BITS'(1 << SHIFT);
    return coeffs;
  endfunction

  localparam logic [KERNEL_BITS-1:0] IDENTITY_KERNEL = identity_kernel();
  localparam int                     BIAS_SHIFT      = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_BITS:0] ROUND_BIAS =
    (SHIFT > 0) ? ((ACC_BITS+1)'(1) << BIAS_SHIFT) : '0;
  localparam logic signed [ACC_BITS:0] PIXEL_MAX = (ACC_BITS+1)'((1 << ITEM_BITS) - 1);

  logic                               stall;
  logic [KERNEL_BITS-1:0]             kernel_q;
  logic [WINDOW_ITEMS*PROD_BITS-1:0]  products;
  logic [WINDOW_ITEMS*PROD_BITS-1:0]  s1_products;
  logic                               s1_valid;
  logic                               s2_valid;
  logic                               s3_valid;
  TagType                             s1_row;
  TagType                             s1_column;
  TagType                             s2_row;
  TagType                             s2_column;
  TagType                             s3_row;
  TagType                             s3_column;
  logic signed [ACC_BITS-1:0]         tree_sum;
  logic signed [ACC_BITS-1:0]         s2_sum;
  logic signed [ACC_BITS:0]           rounded;
  logic signed [ACC_BITS:0]           shifted;
  logic [ITEM_BITS-1:0]               pixel_next;
  logic [ITEM_BITS-1:0]               s3_pixel;

  // The whole pipeline freezes when the output is offered but not taken.
  assign stall                   = s3_valid && !pixel_master_port.ready;
  assign window_slave_port.ready = !stall;

  // A load and a window accepted on the same edge: the window sees kernel_q
  // before the update, so it still uses the old coefficients.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      kernel_q <= IDENTITY_KERNEL;
    end else if (kernel_load_i) begin
      kernel_q <= kernel_i;
    end
  end

  for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_row
    for (genvar c = 0; c < KERNEL_SIZE; c++) begin : g_column
      localparam int IDX = window_index(r, c, KERNEL_SIZE);
      logic signed [PROD_BITS-1:0] pixel_ext;
      logic signed [PROD_BITS-1:0] coeff_ext;
      assign pixel_ext = PROD_BITS'($signed({1'b0, window_slave_port.data[IDX*ITEM_BITS +: ITEM_BITS]}));
      assign coeff_ext = PROD_BITS'($signed(kernel_q[IDX*COEFF_BITS +: COEFF_BITS]));
      assign products[IDX*PROD_BITS +: PROD_BITS] = pixel_ext * coeff_ext;
    end
  end

  signed_adder_tree #(
    .N       (WINDOW_ITEMS),
    .IN_BITS (PROD_BITS)
  ) u_adder_tree (
    .operands (s1_products),
    .sum      (tree_sum)
  );

  // Round half up, floor-shift, then clip into the unsigned pixel range.
  always_comb begin
    rounded    = (ACC_BITS+1)'(s2_sum) + ROUND_BIAS;
    shifted    = rounded >>> SHIFT;
    pixel_next = shifted[ITEM_BITS-1:0];
    if (shifted[ACC_BITS]) begin
      pixel_next = '0;
    end else if (shifted > PIXEL_MAX) begin
      pixel_next = '1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s1_valid    <= 1'b0;
      s1_row      <= '0;
      s1_column   <= '0;
      s1_products <= '0;
      s2_valid    <= 1'b0;
      s2_row      <= '0;
      s2_column   <= '0;
      s2_sum      <= '0;
      s3_valid    <= 1'b0;
      s3_row      <= '0;
      s3_column   <= '0;
      s3_pixel    <= '0;
    end else if (!stall) begin
      s1_valid    <= window_slave_port.valid;
      s1_row      <= window_slave_port.row;
      s1_column   <= window_slave_port.column;
      s1_products <= products;
      s2_valid    <= s1_valid;
      s2_row      <= s1_row;
      s2_column   <= s1_column;
      s2_sum      <= tree_sum;
      s3_valid    <= s2_valid;
      s3_row      <= s2_row;
      s3_column   <= s2_column;
      s3_pixel    <= pixel_next;
    end
  end

  assign pixel_master_port.valid  = s3_valid;
  assign pixel_master_port.data   = s3_pixel;
  assign pixel_master_port.row    = s3_row;
  assign pixel_master_port.column = s3_column;

endmodule

// File: tb/tb_window_convolution.sv
// Directed-plus-random bench for window_convolution against an arithmetic
// convolution model with a frozen-on-stall latency scoreboard.
module tb_window_convolution;
  import image_pkg::*;

  localparam int K       = 3;
  localparam int N       = K * K;
  localparam int IB      = 8;
  localparam int CB      = 8;
  localparam int SH      = 4;
  localparam int LATENCY = 3;

  logic            clock_i = 1'b0;
  logic            reset_ni = 1'b1;
  logic [N*CB-1:0] kernel_i;
  logic            kernel_load_i;

  internal_axi4_stream_if #(.DATA_BITS(N*IB)) win_if ();
  internal_axi4_stream_if #(.DATA_BITS(IB))   pix_if ();

  window_convolution #(
    .ITEM_BITS   (IB),
    .KERNEL_SIZE (K),
    .COEFF_BITS  (CB),
    .SHIFT       (SH)
  ) dut (
    .clock_i           (clock_i),
    .reset_ni          (reset_ni),
    .window_slave_port (win_if),
    .pixel_master_port (pix_if),
    .kernel_i          (kernel_i),
    .kernel_load_i     (kernel_load_i)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    int pixel;
    int row;
    int column;
    int remaining;
  } expected_t;

  expected_t expected_q[$];
  int        items[N];
  int        load_coeffs[N];
  int        kernel_model[N];
  int        checks   = 0;
  int        failures = 0;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Convolution straight from the arithmetic definition: weighted sum,
  // round half up, floor divide by 2^SH, clip to 0..255.
  function automatic int modelPixel();
    int acc;
    int quotient;
    acc = 0;
    for (int i = 0; i < N; i++) acc += items[i] * kernel_model[i];
    acc += 1 << (SH - 1);
    if (acc >= 0) quotient = acc / (1 << SH);
    else          quotient = -((-acc + (1 << SH) - 1) / (1 << SH));
    if (quotient < 0)   return 0;
    if (quotient > 255) return 255;
    return quotient;
  endfunction

  function automatic logic [N*IB-1:0] packItems();
    logic [N*IB-1:0] packed_items;
    for (int i = 0; i < N; i++) packed_items[i*IB +: IB] = IB'(items[i]);
    return packed_items;
  endfunction

  function automatic logic [N*CB-1:0] packKernel();
    logic [N*CB-1:0] packed_kernel;
    for (int i = 0; i < N; i++) packed_kernel[i*CB +: CB] = CB'(load_coeffs[i]);
    return packed_kernel;
  endfunction

  task automatic setUniformItems(input int value);
    for (int i = 0; i < N; i++) items[i] = value;
  endtask

  task automatic setUniformCoeffs(input int value);
    for (int i = 0; i < N; i++) load_coeffs[i] = value;
  endtask

  task automatic setIdentityModel();
    for (int i = 0; i < N; i++) kernel_model[i] = 0;
    kernel_model[N/2] = 1 << SH;
  endtask

  // Output side: the head of the scoreboard is due once it has seen LATENCY
  // advancing edges; ready must follow the stall it implies.
  task automatic checkOutput(input bit out_ready, output bit stalled);
    bit exp_valid;
    exp_valid = (expected_q.size() > 0) && (expected_q[0].remaining == 0);
    checkValue("out_valid", 32'(pix_if.valid), 32'(exp_valid));
    stalled = exp_valid && !out_ready;
    checkValue("in_ready", 32'(win_if.ready), 32'(!stalled));
    if (exp_valid) begin
      checkValue("pixel", 32'(pix_if.data), expected_q[0].pixel);
      checkValue("row", 32'(pix_if.row), expected_q[0].row);
      checkValue("column", 32'(pix_if.column), expected_q[0].column);
      if (out_ready) void'(expected_q.pop_front());
    end
  endtask

  task automatic applyStimulus(input bit in_valid, input int row, input int column,
                               input bit out_ready, input bit load, output bit accepted);
    bit        stalled;
    expected_t entry;
    @(negedge clock_i);
    win_if.valid  = in_valid;
    win_if.data   = packItems();
    win_if.row    = TAG_BITS'(row);
    win_if.column = TAG_BITS'(column);
    pix_if.ready  = out_ready;
    kernel_load_i = load;
    kernel_i      = packKernel();
    #1;
    checkOutput(out_ready, stalled);
    accepted = in_valid && !stalled;
    if (accepted) begin
      entry.pixel     = modelPixel();
      entry.row       = row;
      entry.column    = column;
      entry.remaining = LATENCY;
      expected_q.push_back(entry);
    end
    if (!stalled) begin
      foreach (expected_q[i]) if (expected_q[i].remaining > 0) expected_q[i].remaining--;
    end
    if (load) kernel_model = load_coeffs;
  endtask

  task automatic idle(input int cycles);
    bit accepted;
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, accepted);
  endtask

  task automatic doReset();
    @(negedge clock_i);
    win_if.valid  = 1'b0;
    pix_if.ready  = 1'b1;
    kernel_load_i = 1'b0;
    reset_ni      = 1'b0;
    #1;
    checkValue("reset_valid", 32'(pix_if.valid), 0);
    checkValue("reset_data", 32'(pix_if.data), 0);
    checkValue("reset_row", 32'(pix_if.row), 0);
    checkValue("reset_column", 32'(pix_if.column), 0);
    checkValue("reset_ready", 32'(win_if.ready), 1);
    expected_q.delete();
    setIdentityModel();
    repeat (2) @(negedge clock_i);
    reset_ni = 1'b1;
  endtask

  initial begin
    bit accepted;
    int accepted_count;
    bit seen_output;
    int low_left;

    win_if.valid  = 1'b0;
    win_if.data   = '0;
    win_if.row    = '0;
    win_if.column = '0;
    pix_if.ready  = 1'b1;
    kernel_i      = '0;
    kernel_load_i = 1'b0;
    setUniformItems(0);
    setUniformCoeffs(0);
    setIdentityModel();
    $display("[TB] window_convolution bench starting");

    doReset();
    idle(2);

    // Identity kernel out of reset passes the centre item through.
    setUniformItems(0);
    items[N/2] = 137;
    applyStimulus(1'b1, 5, 7, 1'b1, 1'b0, accepted);
    idle(4);

    // All coefficients 2, uniform 100: (1800 + 8) >> 4 = 113.
    setUniformCoeffs(2);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, accepted);
    setUniformItems(100);
    applyStimulus(1'b1, 1, 2, 1'b1, 1'b0, accepted);
    idle(4);

    // Positive saturation: 2295 clips to 255.
    setUniformCoeffs(16);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, accepted);
    setUniformItems(255);
    applyStimulus(1'b1, 3, 4, 1'b1, 1'b0, accepted);
    idle(4);

    // Negative saturation: neighbours -16, centre 0.
    setUniformCoeffs(-16);
    load_coeffs[N/2] = 0;
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, accepted);
    setUniformItems(200);
    applyStimulus(1'b1, 6, 8, 1'b1, 1'b0, accepted);
    idle(4);

    // Six random windows through a random kernel, ready held low for five
    // cycles once the first pixel is due.
    for (int i = 0; i < N; i++) load_coeffs[i] = int'($urandom_range(0, 255)) - 128;
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, accepted);
    accepted_count = 0;
    seen_output    = 1'b0;
    low_left       = 5;
    for (int i = 0; i < N; i++) items[i] = int'($urandom_range(0, 255));
    for (int cyc = 0; cyc < 40 && !(accepted_count == 6 && expected_q.size() == 0); cyc++) begin
      bit out_ready;
      out_ready = !(seen_output && low_left > 0);
      if (seen_output && low_left > 0) low_left--;
      applyStimulus(accepted_count < 6, 100 + accepted_count, 200 + accepted_count,
                    out_ready, 1'b0, accepted);
      if (accepted) begin
        accepted_count++;
        for (int i = 0; i < N; i++) items[i] = int'($urandom_range(0, 255));
      end
      if (expected_q.size() > 0 && expected_q[0].remaining == 0) seen_output = 1'b1;
    end
    checkValue("burst_accepted", accepted_count, 6);
    checkValue("burst_drained", expected_q.size(), 0);

    // Random soak: random valid, ready, kernel reloads and tags.
    for (int cyc = 0; cyc < 60; cyc++) begin
      bit load;
      load = ($urandom_range(0, 7) == 0);
      if (load) for (int i = 0; i < N; i++) load_coeffs[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < N; i++) items[i] = int'($urandom_range(0, 255));
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 65535)), $urandom_range(0, 3) != 0, load, accepted);
    end
    for (int d = 0; d < 30 && expected_q.size() > 0; d++) idle(1);
    checkValue("soak_drained", expected_q.size(), 0);

    // Load in the same cycle as window A: A uses identity, B uses all-2.
    setUniformCoeffs(0);
    load_coeffs[N/2] = 1 << SH;
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, accepted);
    setUniformCoeffs(2);
    setUniformItems(100);
    applyStimulus(1'b1, 10, 11, 1'b1, 1'b1, accepted);
    applyStimulus(1'b1, 12, 13, 1'b1, 1'b0, accepted);
    idle(4);

    // Reset with three windows in flight: nothing stale emerges afterwards
    // and the kernel returns to identity.
    setUniformCoeffs(2);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, accepted);
    setUniformItems(50);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 20 + i, 30 + i, 1'b1, 1'b0, accepted);
    doReset();
    idle(5);
    setUniformItems(0);
    items[N/2] = 137;
    applyStimulus(1'b1, 40, 41, 1'b1, 1'b0, accepted);
    idle(4);
    checkValue("final_drained", expected_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_convolution.md
# window_convolution

Pipelined 2-D convolution stage that sits directly downstream of `sliding_window`. Consumes one KERNEL_SIZE×KERNEL_SIZE window per handshake, multiplies it element-wise by a runtime-loadable signed kernel, then sums, rounds, shifts and saturates the result to one ITEM_BITS pixel. Row/column tags pass through unchanged, so the output is a scalar pixel stream for the next filter or output stage.

## Interface
- ITEM_BITS, 8, unsigned pixel width (input items and output pixel)
- KERNEL_SIZE, 3, window edge length; must match the upstream `sliding_window`
- COEFF_BITS, 8, signed two's-complement coefficient width
- SHIFT, 4, right-shift applied to the sum (fixed-point fraction bits of coefficients)
- Ports:
- clock_i  in  1  single clock; all logic on posedge
- reset_ni  in  1  asynchronous, active-low reset
- window_slave_port  internal_axi4_stream_if.slave  data = KERNEL_SIZE·KERNEL_SIZE·ITEM_BITS; valid/ready/row/column; element [i][j] at bits ((i·K+j)·ITEM_BITS) upward; i = row from top, j = column from left; [K-1][K-1] is the newest (southeast) item
- pixel_master_port  internal_axi4_stream_if.master  data = ITEM_BITS; valid/ready/row/column
- kernel_i  in  K·K·COEFF_BITS  coefficients, same flattening as window data
- kernel_load_i  in  1  single-cycle load strobe for kernel_i

## Operation
- Pipeline: S1 register K·K products (pixel zero-extended to ITEM_BITS+1 signed × coefficient) plus row/column; S2 register signed sum of products via adder tree; S3 register rounded, shifted, clipped pixel and drive master port.
- Product width ITEM_BITS+1+COEFF_BITS; sum width product width + $clog2(K·K); no internal overflow possible.
- Rounding: add 2^(SHIFT-1) when SHIFT>0, then arithmetic shift right by SHIFT.
- Saturation: result <0 → 0; result >2^ITEM_BITS−1 → 2^ITEM_BITS−1; otherwise low ITEM_BITS bits.
- Kernel register: on kernel_load_i=1, kernel_i is captured at that clock edge. A window accepted in the same cycle as a load uses the old kernel; windows accepted in later cycles use the new kernel. Windows already in flight are never affected.
- Reset kernel value is identity: center coefficient [(K−1)/2][(K−1)/2] = 2^SHIFT, all others 0.
- Row/column carried unmodified through all stages alongside valid.

## Timing
- Reset (async assert, sync release): all stage valids 0; pixel_master_port.valid/data/row/column = 0; window_slave_port.ready = 1; kernel = identity. Reset mid-operation discards all in-flight windows with no output.
- Latency: 3 cycles from input handshake to pixel_master_port.valid, with no backpressure. Throughput is 1 window/cycle.
- Global stall: stall = pixel_master_port.valid && !pixel_master_port.ready. While stalled, every stage holds its contents, and window_slave_port.ready = !stall (combinational).
- Bubbles advance without stall: an invalid stage may be overwritten even while downstream is stalled only if the pipeline is not globally stalled. No bubble collapsing is required.
- Output is held stable (valid, data, row, column) until a handshake occurs. No data is dropped or duplicated, and order is preserved.
- Simultaneous kernel_load_i and stall: the load still takes effect at that edge.

## Structure
- The shared package `image_pkg` provides the ItemType and CoeffType typedefs, product/sum width constants, and a window-indexing helper function. `sliding_window` uses the same package.
- Sub-module `signed_adder_tree` (parameters N, IN_BITS): combinational reduction of N signed operands, instantiated inside S2.
- Rounding/saturation stays inline in S3.

## Test plan
All scenarios use defaults (K=3, COEFF_BITS=8, SHIFT=4).
- Reset, no load; window with center=137 and all other items 0 → pixel 137 after exactly 3 cycles, same row/column as the input.
- Load all coefficients=2; uniform window 100 → (1800+8)>>4 = 113.
- Load all coefficients=16; uniform window 255 → 2295, clipped to 255. Load neighbours=−16 and center=0; neighbours 200 → negative, clipped to 0.
- Stream 6 windows; hold pixel_master_port.ready low for 5 cycles after the first output → window_slave_port.ready drops, output is held stable, and all 6 pixels emerge in order with correct row/column.
- Pulse kernel_load_i (all 2) in the same cycle window A is accepted, then accept window B next cycle, both uniform 100 → A = 100 (identity), B = 113.
- Assert reset_ni low while 3 windows are in flight → outputs go to 0 immediately and valid=0. After release, no stale pixels appear and the kernel is back to identity.
